// File: rtl/i2s_output_pkg.sv
// Shared constants and payload types for the I2S output transmitter.
package i2s_output_pkg;

    localparam int unsigned BCLK_DIVIDE_DEF = 8;
    localparam int unsigned MCLK_DIVIDE_DEF = 2;
    localparam int unsigned SAMPLE_BITS_DEF = 16;
    localparam int unsigned CHAN_W          = 16;
    localparam int unsigned WORD_W          = 2 * CHAN_W;
    localparam int unsigned DIV_W           = 8;

    typedef struct packed {
        logic [CHAN_W-1:0] left;
        logic [CHAN_W-1:0] right;
    } sample_t;

    // Serial frame width: one left and one right channel.
    function automatic int unsigned frame_bits(input int unsigned sample_bits);
        return 2 * sample_bits;
    endfunction

endpackage

// File: rtl/i2s_output_if.sv
// Sample-producer handshake into the I2S transmitter.
interface i2s_output_if;
    import i2s_output_pkg::*;

    sample_t in1;
    logic    in1_stb;
    logic    in1_ack;

    modport master (output in1, output in1_stb, input in1_ack);
    modport slave  (input in1, input in1_stb, output in1_ack);
endinterface

// File: rtl/i2s_clock_gen.sv
// Free-running mclk and bclk dividers plus the bclk falling-event strobe.
module i2s_clock_gen
    import i2s_output_pkg::*;
#(
    parameter int unsigned BCLK_DIVIDE = BCLK_DIVIDE_DEF,
    parameter int unsigned MCLK_DIVIDE = MCLK_DIVIDE_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic mclk_o,
    output logic bclk_o,
    output logic fall_c
);

    localparam logic [DIV_W-1:0] MCLK_TERM = DIV_W'(MCLK_DIVIDE - 1);
    localparam logic [DIV_W-1:0] BCLK_TERM = DIV_W'(BCLK_DIVIDE - 1);

    logic [DIV_W-1:0] mclk_cnt_q, mclk_cnt_d;
    logic [DIV_W-1:0] bclk_cnt_q, bclk_cnt_d;
    logic             mclk_q, mclk_d;
    logic             bclk_q, bclk_d;

    always_comb begin
        mclk_cnt_d = mclk_cnt_q + DIV_W'(1);
        mclk_d     = mclk_q;
        bclk_cnt_d = bclk_cnt_q + DIV_W'(1);
        bclk_d     = bclk_q;
        if (mclk_cnt_q == MCLK_TERM) begin
            mclk_cnt_d = '0;
            mclk_d     = ~mclk_q;
        end
        if (bclk_cnt_q == BCLK_TERM) begin
            bclk_cnt_d = '0;
            bclk_d     = ~bclk_q;
        end
    end

    // High on the cycle whose closing edge drives bclk 1->0.
    assign fall_c = (bclk_cnt_q == BCLK_TERM) && bclk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mclk_cnt_q <= '0;
            bclk_cnt_q <= '0;
            mclk_q     <= 1'b0;
            bclk_q     <= 1'b0;
        end else begin
            mclk_cnt_q <= mclk_cnt_d;
            bclk_cnt_q <= bclk_cnt_d;
            mclk_q     <= mclk_d;
            bclk_q     <= bclk_d;
        end
    end

    assign mclk_o = mclk_q;
    assign bclk_o = bclk_q;

endmodule

// File: rtl/i2s_output.sv
// I2S transmitter: one-entry sample holding register, slot counter and frame shifter.
module i2s_output
    import i2s_output_pkg::*;
#(
    parameter int unsigned BCLK_DIVIDE = BCLK_DIVIDE_DEF,
    parameter int unsigned MCLK_DIVIDE = MCLK_DIVIDE_DEF,
    parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    i2s_output_if.slave  in_bus,
    output logic         mclk_out,
    output logic         bclk_out,
    output logic         lrclk_out,
    output logic         dout_out,
    output logic         underrun_out
);

    localparam int unsigned FRAME_BITS = frame_bits(SAMPLE_BITS);
    localparam int unsigned SLOT_W     = $clog2(FRAME_BITS);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LOAD  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(SAMPLE_BITS);

    logic                  fall;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic                  lrclk_q, lrclk_d;
    logic                  dout_q, dout_d;
    logic                  undr_q, undr_d;
    logic                  ack_q, ack_d;
    logic                  hold_valid_q, hold_valid_d;
    sample_t               hold_q, hold_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] frame_word;
    logic [FRAME_BITS-1:0] load_word;

    i2s_clock_gen #(
        .BCLK_DIVIDE (BCLK_DIVIDE),
        .MCLK_DIVIDE (MCLK_DIVIDE)
    ) u_clock_gen (
        .clk    (clk),
        .rst    (rst),
        .mclk_o (mclk_out),
        .bclk_o (bclk_out),
        .fall_c (fall)
    );

    // Narrower channels take the most significant bits of each half-word.
    assign frame_word = {hold_q.left[CHAN_W-1 -: SAMPLE_BITS],
                         hold_q.right[CHAN_W-1 -: SAMPLE_BITS]};

    always_comb begin
        slot_d       = slot_q;
        lrclk_d      = lrclk_q;
        dout_d       = dout_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        undr_d       = 1'b0;
        ack_d        = 1'b0;
        load_word    = '0;

        if (fall) begin
            slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            lrclk_d = (slot_d >= SLOT_RIGHT);
            if (slot_d == SLOT_LOAD) begin
                load_word    = hold_valid_q ? frame_word : '0;
                shift_d      = load_word;
                dout_d       = load_word[FRAME_BITS-1];
                undr_d       = ~hold_valid_q;
                hold_valid_d = 1'b0;
            end else begin
                // Data lags lrclk by one slot, so slot 0 emits the last word's LSB.
                shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                dout_d  = shift_q[FRAME_BITS-2];
            end
        end

        // Capture uses the pre-load valid flag, so a load always empties first.
        if (!hold_valid_q && !ack_q && in_bus.in1_stb) begin
            hold_d       = in_bus.in1;
            hold_valid_d = 1'b1;
            ack_d        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            lrclk_q      <= 1'b0;
            dout_q       <= 1'b0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            undr_q       <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            lrclk_q      <= lrclk_d;
            dout_q       <= dout_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            undr_q       <= undr_d;
            ack_q        <= ack_d;
        end
    end

    assign lrclk_out      = lrclk_q;
    assign dout_out       = dout_q;
    assign underrun_out   = undr_q;
    assign in_bus.in1_ack = ack_q;

endmodule

// File: tb/tb_i2s_output.sv
// Directed bench for i2s_output at BCLK_DIVIDE=2, MCLK_DIVIDE=3, SAMPLE_BITS=16.
module tb_i2s_output;
    import i2s_output_pkg::*;

    logic clk;
    logic rst;
    logic mclk_out, bclk_out, lrclk_out, dout_out, underrun_out;
    int   c;
    int   checks;
    int   errors;
    logic ack_prev;

    i2s_output_if bus ();

    i2s_output #(
        .BCLK_DIVIDE (2),
        .MCLK_DIVIDE (3),
        .SAMPLE_BITS (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_bus       (bus),
        .mclk_out     (mclk_out),
        .bclk_out     (bclk_out),
        .lrclk_out    (lrclk_out),
        .dout_out     (dout_out),
        .underrun_out (underrun_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release: c=1 is the state after the first edge with rst low.
    always @(posedge clk) c <= rst ? 0 : c + 1;

    typedef struct {
        int   cyc;
        logic mclk;
        logic bclk;
        logic lrclk;
        logic undr;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (c=%0d)", name, got, exp, c);
        end
    endtask

    task automatic wait_c(input int target);
        int n;
        n = 0;
        if (c > target) begin
            checks++;
            errors++;
            $display("FAIL wait_c: c=%0d already past target %0d", c, target);
            return;
        end
        while (c != target && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (c != target) begin
            checks++;
            errors++;
            $display("FAIL wait_c_timeout: c=%0d target %0d", c, target);
        end
    endtask

    task automatic do_reset(input bit check_outputs);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.in1_stb = 1'b0;
        bus.in1     = sample_t'(32'h0);
        repeat (2) @(posedge clk);
        #1;
        if (check_outputs) begin
            chk("rst_mclk",  32'(mclk_out),     32'h0);
            chk("rst_bclk",  32'(bclk_out),     32'h0);
            chk("rst_lrclk", 32'(lrclk_out),    32'h0);
            chk("rst_dout",  32'(dout_out),     32'h0);
            chk("rst_undr",  32'(underrun_out), 32'h0);
            chk("rst_ack",   32'(bus.in1_ack),  32'h0);
        end
        rst = 1'b0;
    endtask

    // Check one serial frame f (slots 1..31) and the following slot 0.
    task automatic check_frame(input int f, input logic [31:0] exp, input logic exp_u);
        int base;
        base = 128 * f;
        wait_c(base + 4);
        chk($sformatf("f%0d_undr", f),     32'(underrun_out), 32'(exp_u));
        chk($sformatf("f%0d_s1_dout", f),  32'(dout_out),     32'(exp[31]));
        chk($sformatf("f%0d_s1_lrclk", f), 32'(lrclk_out),    32'h0);
        wait_c(base + 5);
        chk($sformatf("f%0d_undr_end", f), 32'(underrun_out), 32'h0);
        for (int s = 2; s < 32; s++) begin
            wait_c(base + 4 * s);
            chk($sformatf("f%0d_s%0d_dout", f, s),  32'(dout_out),  32'(exp[32-s]));
            chk($sformatf("f%0d_s%0d_lrclk", f, s), 32'(lrclk_out), 32'(s >= 16));
        end
        wait_c(base + 128);
        chk($sformatf("f%0d_s0_dout", f),  32'(dout_out),  32'(exp[0]));
        chk($sformatf("f%0d_s0_lrclk", f), 32'(lrclk_out), 32'h0);
    endtask

    // Accept pulses must never occur on consecutive cycles.
    always @(negedge clk) begin
        if (rst) begin
            ack_prev <= 1'b0;
        end else begin
            checks++;
            if (bus.in1_ack && ack_prev) begin
                errors++;
                $display("FAIL ack_consecutive: got 1 after 1 expected 0 (c=%0d)", c);
            end
            ack_prev <= bus.in1_ack;
        end
    end

    initial begin
        int acks;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.in1_stb = 1'b0;
        bus.in1     = sample_t'(32'h0);

        vecs[0]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4,   1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{5,   1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{6,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{9,   1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{63,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{64,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{127, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{128, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{129, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{132, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{133, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{260, 1'b0, 1'b0, 1'b0, 1'b1};

        // Idle: clock waveforms and one underrun per frame, no data.
        do_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            wait_c(vecs[i].cyc);
            chk($sformatf("v%0d_mclk", i),  32'(mclk_out),     32'(vecs[i].mclk));
            chk($sformatf("v%0d_bclk", i),  32'(bclk_out),     32'(vecs[i].bclk));
            chk($sformatf("v%0d_lrclk", i), 32'(lrclk_out),    32'(vecs[i].lrclk));
            chk($sformatf("v%0d_undr", i),  32'(underrun_out), 32'(vecs[i].undr));
            chk($sformatf("v%0d_dout", i),  32'(dout_out),     32'h0);
            chk($sformatf("v%0d_ack", i),   32'(bus.in1_ack),  32'h0);
        end

        // Single sample serialised MSB first, LSB in the next frame's slot 0.
        do_reset(1'b0);
        bus.in1     = sample_t'(32'hA5A50F0F);
        bus.in1_stb = 1'b1;
        wait_c(1);
        chk("a5_ack", 32'(bus.in1_ack), 32'h1);
        bus.in1_stb = 1'b0;
        check_frame(0, 32'hA5A50F0F, 1'b0);

        // Back-to-back samples with backpressure until the slot-1 load.
        do_reset(1'b0);
        bus.in1     = sample_t'(32'h00010002);
        bus.in1_stb = 1'b1;
        fork
            begin
                wait_c(1);
                chk("bb_ack1", 32'(bus.in1_ack), 32'h1);
                bus.in1 = sample_t'(32'h00030004);
                wait_c(2);
                chk("bb_ack_c2", 32'(bus.in1_ack), 32'h0);
                wait_c(3);
                chk("bb_ack_c3", 32'(bus.in1_ack), 32'h0);
                wait_c(4);
                chk("bb_ack_c4", 32'(bus.in1_ack), 32'h0);
                wait_c(5);
                chk("bb_ack2", 32'(bus.in1_ack), 32'h1);
                bus.in1_stb = 1'b0;
            end
            begin
                check_frame(0, 32'h00010002, 1'b0);
                check_frame(1, 32'h00030004, 1'b0);
                check_frame(2, 32'h00000000, 1'b1);
            end
        join

        // Mid-frame reset discards the held sample without a second ack.
        do_reset(1'b0);
        bus.in1     = sample_t'(32'h12345678);
        bus.in1_stb = 1'b1;
        wait_c(1);
        chk("mr_ack1", 32'(bus.in1_ack), 32'h1);
        bus.in1_stb = 1'b0;
        wait_c(5);
        bus.in1     = sample_t'(32'hDEADBEEF);
        bus.in1_stb = 1'b1;
        wait_c(6);
        chk("mr_ack2", 32'(bus.in1_ack), 32'h1);
        bus.in1_stb = 1'b0;
        wait_c(80);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_bclk",  32'(bclk_out),     32'h0);
        chk("mr_mclk",  32'(mclk_out),     32'h0);
        chk("mr_lrclk", 32'(lrclk_out),    32'h0);
        chk("mr_dout",  32'(dout_out),     32'h0);
        chk("mr_undr",  32'(underrun_out), 32'h0);
        chk("mr_ack",   32'(bus.in1_ack),  32'h0);
        rst  = 1'b0;
        acks = 0;
        fork
            begin
                for (int i = 1; i <= 140; i++) begin
                    wait_c(i);
                    acks += int'(bus.in1_ack);
                end
                chk("mr_no_ack", 32'(acks), 32'h0);
            end
            check_frame(0, 32'h00000000, 1'b1);
        join

        // Strobe rising exactly on the load cycle: underrun now, sample next frame.
        do_reset(1'b0);
        fork
            begin
                wait_c(3);
                chk("ex_ack_c3", 32'(bus.in1_ack), 32'h0);
                bus.in1     = sample_t'(32'h0F0F5A5A);
                bus.in1_stb = 1'b1;
                wait_c(4);
                chk("ex_ack", 32'(bus.in1_ack), 32'h1);
                bus.in1_stb = 1'b0;
            end
            begin
                check_frame(0, 32'h00000000, 1'b1);
                check_frame(1, 32'h0F0F5A5A, 1'b0);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
